// File: rtl/softmax_seq_ctrl.sv
// rtl/softmax_seq_ctrl.sv - sequencer for one softmax vector pass (load, exp/accumulate, divide)
//
// Purpose: counts the input stream into the shared buffer, then walks every
// element through the shared exp unit (pulsing the accumulator on each result)
// and then through the shared divider (flagging each output element). All
// indices and handshakes live here; the datapath units are stateless.
//
// Ports:
//   clock_i, reset_i            clock, synchronous active-high reset
//   start_i                     begin a pass (honoured only in IDLE/ERROR)
//   data_valid_i                stream element present
//   wr_en_o, wr_addr_o          buffer write
//   exp_req_o, exp_idx_o        exp unit request / index
//   exp_ack_i                   exp result valid
//   acc_en_o, acc_clr_o         accumulator enable / clear
//   div_req_o, div_idx_o        divider request / index
//   div_ack_i                   divider result valid
//   out_valid_o, out_idx_o      softmax output element valid / index
//   busy_o, done_o, err_o       pass in progress, completion pulse, sticky timeout
module softmax_seq_ctrl #(
    parameter int NUMBER_OF_DATA = 10,
    parameter int IDX_W          = 8,
    parameter int TIMEOUT        = 64
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             data_valid_i,
    output logic             wr_en_o,
    output logic [IDX_W-1:0] wr_addr_o,
    output logic             exp_req_o,
    output logic [IDX_W-1:0] exp_idx_o,
    input  logic             exp_ack_i,
    output logic             acc_en_o,
    output logic             acc_clr_o,
    output logic             div_req_o,
    output logic [IDX_W-1:0] div_idx_o,
    input  logic             div_ack_i,
    output logic             out_valid_o,
    output logic [IDX_W-1:0] out_idx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUMBER_OF_DATA - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, EXP_ISSUE, EXP_WAIT, DIV_ISSUE, DIV_WAIT, DONE, ERROR
    } state_t;

    state_t            state, next_state;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [IDX_W-1:0]  load_cnt, load_cnt_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;

    logic             wr_en_d, exp_req_d, acc_en_d, acc_clr_d, div_req_d, out_valid_d;
    logic             busy_d, done_d, err_d;
    logic [IDX_W-1:0] wr_addr_d, exp_idx_d, div_idx_d, out_idx_d;

    // The request is visible during the first WAIT cycle; an ack in that same
    // cycle is too early to be a response, so it is not counted.
    logic exp_ack_ok, div_ack_ok, wait_expired;
    assign exp_ack_ok   = exp_ack_i && !exp_req_o;
    assign div_ack_ok   = div_ack_i && !div_req_o;
    // This cycle's missing ack would bring the counter to TIMEOUT.
    assign wait_expired = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state       <= IDLE;
            idx         <= '0;
            load_cnt    <= '0;
            wait_cnt    <= '0;
            wr_en_o     <= 1'b0;
            wr_addr_o   <= '0;
            exp_req_o   <= 1'b0;
            exp_idx_o   <= '0;
            acc_en_o    <= 1'b0;
            acc_clr_o   <= 1'b0;
            div_req_o   <= 1'b0;
            div_idx_o   <= '0;
            out_valid_o <= 1'b0;
            out_idx_o   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state       <= next_state;
            idx         <= idx_next;
            load_cnt    <= load_cnt_next;
            wait_cnt    <= wait_cnt_next;
            wr_en_o     <= wr_en_d;
            wr_addr_o   <= wr_addr_d;
            exp_req_o   <= exp_req_d;
            exp_idx_o   <= exp_idx_d;
            acc_en_o    <= acc_en_d;
            acc_clr_o   <= acc_clr_d;
            div_req_o   <= div_req_d;
            div_idx_o   <= div_idx_d;
            out_valid_o <= out_valid_d;
            out_idx_o   <= out_idx_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            err_o       <= err_d;
        end
    end

    always_comb begin
        next_state    = state;
        idx_next      = idx;
        load_cnt_next = load_cnt;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE, ERROR: begin
                if (start_i) begin
                    next_state    = LOAD;
                    idx_next      = '0;
                    load_cnt_next = '0;
                end
            end
            LOAD: begin
                if (data_valid_i) begin
                    if (load_cnt == LAST_IDX) begin
                        next_state = EXP_ISSUE;
                        idx_next   = '0;
                    end else begin
                        load_cnt_next = load_cnt + 1'b1;
                    end
                end
            end
            EXP_ISSUE: begin
                wait_cnt_next = '0;
                next_state    = EXP_WAIT;
            end
            EXP_WAIT: begin
                if (exp_ack_ok) begin
                    if (idx == LAST_IDX) begin
                        next_state = DIV_ISSUE;
                        idx_next   = '0;
                    end else begin
                        next_state = EXP_ISSUE;
                        idx_next   = idx + 1'b1;
                    end
                end else if (wait_expired) begin
                    next_state = ERROR;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            DIV_ISSUE: begin
                wait_cnt_next = '0;
                next_state    = DIV_WAIT;
            end
            DIV_WAIT: begin
                if (div_ack_ok) begin
                    if (idx == LAST_IDX) begin
                        next_state = DONE;
                    end else begin
                        next_state = DIV_ISSUE;
                        idx_next   = idx + 1'b1;
                    end
                end else if (wait_expired) begin
                    next_state = ERROR;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs follow the current state by one cycle; status outputs
    // (busy/done/err/clear) are aligned with the state being entered.
    always_comb begin
        wr_en_d     = (state == LOAD) && data_valid_i;
        wr_addr_d   = wr_en_d ? load_cnt : wr_addr_o;
        exp_req_d   = (state == EXP_ISSUE);
        exp_idx_d   = exp_req_d ? idx : exp_idx_o;
        acc_en_d    = (state == EXP_WAIT) && exp_ack_ok;
        acc_clr_d   = ((state == IDLE) || (state == ERROR)) && start_i;
        div_req_d   = (state == DIV_ISSUE);
        div_idx_d   = div_req_d ? idx : div_idx_o;
        out_valid_d = (state == DIV_WAIT) && div_ack_ok;
        out_idx_d   = out_valid_d ? idx : out_idx_o;
        busy_d      = !((next_state == IDLE) || (next_state == ERROR));
        done_d      = (next_state == DONE);
        err_d       = (next_state == ERROR);
    end
endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// tb/tb_softmax_seq_ctrl.sv - randomized self-checking bench for softmax_seq_ctrl
module tb_softmax_seq_ctrl;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic         clock_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         start_i = 1'b0;
    logic         data_valid_i = 1'b0;
    logic         exp_ack_i = 1'b0;
    logic         div_ack_i = 1'b0;
    logic         wr_en_o, exp_req_o, acc_en_o, acc_clr_o, div_req_o, out_valid_o;
    logic         busy_o, done_o, err_o;
    logic [W-1:0] wr_addr_o, exp_idx_o, div_idx_o, out_idx_o;

    softmax_seq_ctrl #(.NUMBER_OF_DATA(N), .IDX_W(W), .TIMEOUT(TO)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .data_valid_i(data_valid_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
        .exp_req_o(exp_req_o), .exp_idx_o(exp_idx_o), .exp_ack_i(exp_ack_i),
        .acc_en_o(acc_en_o), .acc_clr_o(acc_clr_o),
        .div_req_o(div_req_o), .div_idx_o(div_idx_o), .div_ack_i(div_ack_i),
        .out_valid_o(out_valid_o), .out_idx_o(out_idx_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    initial forever #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check(input string tag, input longint act, input longint exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Stimulus tables: gap cycles before each element, ack latency per index
    // (0 = never acknowledge).
    int   gap_tab[N];
    int   exp_lat_tab[N];
    int   div_lat_tab[N];
    int   wr_exp_t[N];
    logic force_exp_ack = 1'b0;

    // Responder: acks L cycles after the request becomes visible.
    int exp_cd = 0;
    int div_cd = 0;
    always @(posedge clock_i) begin
        #2;
        exp_ack_i = force_exp_ack;
        div_ack_i = 1'b0;
        if (exp_cd > 0) begin exp_cd--; if (exp_cd == 0) exp_ack_i = 1'b1; end
        if (div_cd > 0) begin div_cd--; if (div_cd == 0) div_ack_i = 1'b1; end
        if (exp_req_o && exp_idx_o < N && exp_lat_tab[exp_idx_o] != 0) exp_cd = exp_lat_tab[exp_idx_o];
        if (div_req_o && div_idx_o < N && div_lat_tab[div_idx_o] != 0) div_cd = div_lat_tab[div_idx_o];
    end

    // Event log, sampled on the falling edge.
    int wr_t[$], wr_a[$], er_t[$], er_i[$], ae_t[$], dr_t[$], dr_i[$];
    int ov_t[$], ov_i[$], dn_t[$], cl_t[$], ef_t[$], bf_t[$];
    int   viol = 0;
    logic p_exp_req = 1'b0, p_div_req = 1'b0, p_err = 1'b0, p_busy = 1'b0;
    always @(negedge clock_i) begin
        if (wr_en_o)     begin wr_t.push_back(cyc); wr_a.push_back(int'(wr_addr_o)); end
        if (exp_req_o)   begin er_t.push_back(cyc); er_i.push_back(int'(exp_idx_o)); end
        if (acc_en_o)    ae_t.push_back(cyc);
        if (div_req_o)   begin dr_t.push_back(cyc); dr_i.push_back(int'(div_idx_o)); end
        if (out_valid_o) begin ov_t.push_back(cyc); ov_i.push_back(int'(out_idx_o)); end
        if (done_o)      dn_t.push_back(cyc);
        if (acc_clr_o)   cl_t.push_back(cyc);
        if (err_o && !p_err)   ef_t.push_back(cyc);
        if (!busy_o && p_busy) bf_t.push_back(cyc);
        if ((exp_req_o && p_exp_req) || (div_req_o && p_div_req) || (exp_req_o && div_req_o)) viol++;
        p_exp_req = exp_req_o; p_div_req = div_req_o; p_err = err_o; p_busy = busy_o;
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic start_and_stream(input bit spur, output int t0, output int t_lw);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        t0 = cyc;
        for (int k = 0; k < N; k++) begin
            for (int g = 0; g < gap_tab[k]; g++) begin
                force_exp_ack = spur;
                tick();
            end
            force_exp_ack = 1'b0;
            data_valid_i  = 1'b1;
            tick();
            data_valid_i  = 1'b0;
            wr_exp_t[k]   = cyc;
        end
        t_lw = cyc;
    endtask

    task automatic run_pass(input string nm, input bit spur, input bit mid_start);
        int b_wr, b_er, b_ae, b_dr, b_ov, b_dn, b_cl, b_ef, b_bf;
        int t0, t_lw, t, lat, err_t, done_t, n_exp, n_acc, n_div, n_out;
        int m_er_t[N], m_ae_t[N], m_dr_t[N], m_ov_t[N];
        bit finished;
        b_wr = wr_t.size(); b_er = er_t.size(); b_ae = ae_t.size(); b_dr = dr_t.size();
        b_ov = ov_t.size(); b_dn = dn_t.size(); b_cl = cl_t.size(); b_ef = ef_t.size();
        b_bf = bf_t.size();
        start_and_stream(spur, t0, t_lw);
        if (mid_start) begin
            tick();
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
        end
        finished = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (dn_t.size() > b_dn || ef_t.size() > b_ef) begin finished = 1'b1; break; end
            tick();
        end
        check({nm, ".finished"}, finished, 1);
        repeat (4) tick();

        // Reference timeline: each element costs latency + 2 cycles per phase;
        // an ack latency of 0 or >= TIMEOUT ends the pass in ERROR.
        t = t_lw + 1; err_t = -1; n_exp = 0; n_acc = 0; n_div = 0; n_out = 0;
        for (int k = 0; k < N; k++) begin
            m_er_t[k] = t; n_exp++;
            lat = exp_lat_tab[k];
            if (lat == 0 || lat >= TO) begin err_t = t + TO; break; end
            m_ae_t[k] = t + lat + 1; n_acc++;
            t = t + lat + 2;
        end
        if (err_t < 0) begin
            for (int k = 0; k < N; k++) begin
                m_dr_t[k] = t; n_div++;
                lat = div_lat_tab[k];
                if (lat == 0 || lat >= TO) begin err_t = t + TO; break; end
                m_ov_t[k] = t + lat + 1; n_out++;
                t = t + lat + 2;
            end
        end
        done_t = (err_t < 0) ? t - 1 : -1;

        check({nm, ".wr_count"}, wr_t.size() - b_wr, N);
        for (int k = 0; k < N && k < wr_t.size() - b_wr; k++) begin
            check($sformatf("%s.wr_addr%0d", nm, k), wr_a[b_wr + k], k);
            check($sformatf("%s.wr_time%0d", nm, k), wr_t[b_wr + k], wr_exp_t[k]);
        end
        check({nm, ".clr_count"}, cl_t.size() - b_cl, 1);
        if (cl_t.size() > b_cl) check({nm, ".clr_time"}, cl_t[b_cl], t0);
        check({nm, ".exp_req_count"}, er_t.size() - b_er, n_exp);
        for (int k = 0; k < n_exp && k < er_t.size() - b_er; k++) begin
            check($sformatf("%s.exp_idx%0d", nm, k), er_i[b_er + k], k);
            check($sformatf("%s.exp_time%0d", nm, k), er_t[b_er + k], m_er_t[k]);
        end
        check({nm, ".acc_count"}, ae_t.size() - b_ae, n_acc);
        for (int k = 0; k < n_acc && k < ae_t.size() - b_ae; k++)
            check($sformatf("%s.acc_time%0d", nm, k), ae_t[b_ae + k], m_ae_t[k]);
        check({nm, ".div_req_count"}, dr_t.size() - b_dr, n_div);
        for (int k = 0; k < n_div && k < dr_t.size() - b_dr; k++) begin
            check($sformatf("%s.div_idx%0d", nm, k), dr_i[b_dr + k], k);
            check($sformatf("%s.div_time%0d", nm, k), dr_t[b_dr + k], m_dr_t[k]);
        end
        check({nm, ".out_count"}, ov_t.size() - b_ov, n_out);
        for (int k = 0; k < n_out && k < ov_t.size() - b_ov; k++) begin
            check($sformatf("%s.out_idx%0d", nm, k), ov_i[b_ov + k], k);
            check($sformatf("%s.out_time%0d", nm, k), ov_t[b_ov + k], m_ov_t[k]);
        end
        check({nm, ".busy_fall_count"}, bf_t.size() - b_bf, 1);
        check({nm, ".busy_end"}, busy_o, 0);
        if (err_t < 0) begin
            check({nm, ".done_count"}, dn_t.size() - b_dn, 1);
            if (dn_t.size() > b_dn) check({nm, ".done_time"}, dn_t[b_dn], done_t);
            if (bf_t.size() > b_bf) check({nm, ".busy_fall_time"}, bf_t[b_bf], done_t + 1);
            check({nm, ".err_rise_count"}, ef_t.size() - b_ef, 0);
            check({nm, ".err_end"}, err_o, 0);
        end else begin
            check({nm, ".done_count"}, dn_t.size() - b_dn, 0);
            check({nm, ".err_rise_count"}, ef_t.size() - b_ef, 1);
            if (ef_t.size() > b_ef) check({nm, ".err_time"}, ef_t[b_ef], err_t);
            if (bf_t.size() > b_bf) check({nm, ".busy_fall_time"}, bf_t[b_bf], err_t);
            check({nm, ".err_end"}, err_o, 1);
        end
    endtask

    function automatic longint all_outputs();
        return longint'({wr_en_o, wr_addr_o, exp_req_o, exp_idx_o, acc_en_o, acc_clr_o,
                         div_req_o, div_idx_o, out_valid_o, out_idx_o, busy_o, done_o, err_o});
    endfunction

    task automatic set_tables(input int gap, input int elat, input int dlat);
        for (int k = 0; k < N; k++) begin
            gap_tab[k] = gap; exp_lat_tab[k] = elat; div_lat_tab[k] = dlat;
        end
    endtask

    initial begin
        int b_dn, b_ov, b_dr, t0, t_lw, pick;
        bit got;
        set_tables(0, 3, 3);

        // Reset held with start asserted: nothing may begin.
        reset_i = 1'b1; start_i = 1'b1;
        for (int i = 0; i < 3; i++) begin data_valid_i = 1'($urandom_range(0, 1)); tick(); end
        check("reset.outputs", all_outputs(), 0);
        reset_i = 1'b0; start_i = 1'b0; data_valid_i = 1'b0;
        tick();
        check("reset.busy_after", busy_o, 0);
        repeat (2) tick();

        run_pass("nominal", 1'b0, 1'b0);

        set_tables(0, 2, 2);
        gap_tab[1] = 0; gap_tab[2] = 2; gap_tab[3] = 5;
        for (int k = 0; k < N; k++) begin
            exp_lat_tab[k] = $urandom_range(1, 6); div_lat_tab[k] = $urandom_range(1, 6);
        end
        run_pass("gapped", 1'b1, 1'b1);

        set_tables(0, 3, 3);
        exp_lat_tab[2] = 0;
        run_pass("timeout", 1'b0, 1'b0);
        set_tables(0, 3, 3);
        run_pass("after_timeout", 1'b0, 1'b0);

        exp_lat_tab = '{TO - 1, 1, TO - 1, 2};
        div_lat_tab = '{1, TO - 1, 3, TO - 1};
        run_pass("boundary_ack", 1'b0, 1'b0);
        set_tables(1, 2, 2);
        div_lat_tab[3] = TO;
        run_pass("late_div_ack", 1'b0, 1'b0);

        // Reset while waiting on the divider for idx 1.
        set_tables(0, 2, 2);
        div_lat_tab[1] = 12;
        b_dn = dn_t.size(); b_dr = dr_t.size();
        start_and_stream(1'b0, t0, t_lw);
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (dr_t.size() > b_dr + 1) begin got = 1'b1; break; end
            tick();
        end
        check("midrst.reached_div1", got, 1);
        repeat (2) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("midrst.outputs", all_outputs(), 0);
        b_ov = ov_t.size();
        repeat (15) tick();
        check("midrst.no_done", dn_t.size() - b_dn, 0);
        check("midrst.no_stray_out", ov_t.size() - b_ov, 0);
        set_tables(0, 3, 3);
        run_pass("after_reset", 1'b0, 1'b0);

        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < N; k++) begin
                gap_tab[k]     = $urandom_range(0, 4);
                exp_lat_tab[k] = $urandom_range(1, TO - 1);
                div_lat_tab[k] = $urandom_range(1, TO - 1);
            end
            if ($urandom_range(0, 3) == 0) begin
                pick = $urandom_range(0, 2 * N - 1);
                if (pick < N) exp_lat_tab[pick] = $urandom_range(0, 1) ? 0 : $urandom_range(TO, TO + 4);
                else          div_lat_tab[pick - N] = $urandom_range(0, 1) ? 0 : $urandom_range(TO, TO + 4);
            end
            run_pass($sformatf("rand%0d", p), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        check("request_pulse_rules", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
